// File: rtl/morse_pkg.sv
// Shared Morse definitions: letter codes, symbol patterns (LSB = first symbol),
// FSM state encoding and the pattern lookup used by the receiver.
package morse_pkg;
  typedef enum logic [1:0] {S_IDLE, S_MARK, S_SPACE, S_ERR} state_e;
  typedef logic [2:0] letter_t;

  localparam letter_t L_A = 3'd0, L_B = 3'd1, L_C = 3'd2, L_D = 3'd3,
                      L_E = 3'd4, L_F = 3'd5, L_G = 3'd6, L_H = 3'd7;
  localparam logic SYM_DOT  = 1'b0;
  localparam logic SYM_DASH = 1'b1;

  // Indexed by letter code; unused high pattern bits are zero.
  localparam logic [3:0] PAT [8] = '{4'b0010, 4'b0001, 4'b0101, 4'b0001,
                                     4'b0000, 4'b0100, 4'b0011, 4'b0000};
  localparam logic [2:0] LEN [8] = '{3'd2, 3'd4, 3'd4, 3'd3,
                                     3'd1, 3'd4, 3'd3, 3'd4};

  typedef struct packed {
    logic    hit;
    letter_t code;
  } lookup_t;

  function automatic lookup_t lookup(input logic [3:0] pat, input logic [2:0] len);
    lookup_t r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (!r.hit && pat == PAT[i] && len == LEN[i]) begin
        r.hit  = 1'b1;
        r.code = letter_t'(i);
      end
    return r;
  endfunction
endpackage

// File: rtl/morse_rx_decoder_if.sv
// Key-line input and decoded-letter output bundle of the Morse receiver.
interface morse_rx_decoder_if;
  import morse_pkg::*;
  logic    tick;
  logic    key_in;
  letter_t letter;
  logic    letter_valid;
  logic    letter_err;
  logic    busy;

  modport slave  (input tick, key_in, output letter, letter_valid, letter_err, busy);
  modport master (output tick, key_in, input letter, letter_valid, letter_err, busy);
endinterface

// File: rtl/morse_sync_edge.sv
// Two-flop synchronizer for the raw key line plus rise/fall detect on the
// synchronized level.
module morse_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end

  assign q_o    = s2_q;
  assign rise_o = s2_q & ~s3_q;
  assign fall_o = ~s2_q & s3_q;
endmodule

// File: rtl/morse_rx_decoder.sv
// Morse receiver: times marks/spaces in ticks, builds dot/dash symbols and
// decodes letters A-H. MORSE_RX_GLITCH_EN: sub-tick marks are discarded.
module morse_rx_decoder
  import morse_pkg::*;
#(
  parameter int unsigned DOT_MAX    = 2,
  parameter int unsigned MARK_MAX   = 7,
  parameter int unsigned LETTER_GAP = 3,
  parameter int unsigned CNT_W      = 4
) (
  input  logic clk,
  input  logic reset,
  morse_rx_decoder_if.slave bus
);
  state_e     state_q, state_d;
  logic [CNT_W-1:0] dur_q, dur_d, dur_nx;
  logic [3:0] sym_q, sym_d;
  logic [2:0] cnt_q, cnt_d;
  letter_t    letter_q, letter_d;
  logic       valid_q, valid_d, err_q, err_d;
  logic       key, rise, fall;
  lookup_t    lk;

  morse_sync_edge u_sync (
    .clk(clk), .reset(reset), .d_i(bus.key_in),
    .q_o(key), .rise_o(rise), .fall_o(fall)
  );

  // A tick in the same cycle as an edge belongs to the segment that is ending.
  assign dur_nx = (bus.tick && !(&dur_q)) ? dur_q + CNT_W'(1) : dur_q;
  assign lk     = lookup(sym_q, cnt_q);

`ifdef MORSE_RX_GLITCH_EN
  logic [CNT_W-1:0] save_q;
  logic             from_sp_q;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      save_q    <= '0;
      from_sp_q <= 1'b0;
    end else if (state_q == S_IDLE) begin
      from_sp_q <= 1'b0;
    end else if (state_q == S_SPACE) begin
      from_sp_q <= 1'b1;
      save_q    <= dur_nx;
    end
`endif

  always_comb begin
    state_d  = state_q;
    dur_d    = dur_nx;
    sym_d    = sym_q;
    cnt_d    = cnt_q;
    letter_d = letter_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        dur_d = '0;
        if (key) state_d = S_MARK;
      end
      S_MARK: begin
        if (fall) begin
          dur_d = '0;
          if (dur_nx == '0) begin
`ifdef MORSE_RX_GLITCH_EN
            if (from_sp_q) begin
              state_d = S_SPACE;
              dur_d   = save_q;
            end else begin
              state_d = S_IDLE;
            end
`else
            state_d = S_ERR;
`endif
          end else if (cnt_q == 3'd4) begin
            state_d = S_ERR;
          end else begin
            sym_d[cnt_q[1:0]] = (dur_nx > CNT_W'(DOT_MAX)) ? SYM_DASH : SYM_DOT;
            cnt_d   = cnt_q + 3'd1;
            state_d = S_SPACE;
          end
        end else if (dur_nx > CNT_W'(MARK_MAX)) begin
          state_d = S_ERR;
        end
      end
      S_SPACE: begin
        if (rise && dur_nx < CNT_W'(LETTER_GAP)) begin
          state_d = S_MARK;
          dur_d   = '0;
        end else if (dur_nx >= CNT_W'(LETTER_GAP)) begin
          if (lk.hit) begin
            letter_d = lk.code;
            valid_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          sym_d   = '0;
          cnt_d   = '0;
          dur_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        if (rise || fall) begin
          dur_d = '0;
        end else if (!key && dur_nx >= CNT_W'(LETTER_GAP)) begin
          err_d   = 1'b1;
          sym_d   = '0;
          cnt_d   = '0;
          dur_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q  <= S_IDLE;
      dur_q    <= '0;
      sym_q    <= '0;
      cnt_q    <= '0;
      letter_q <= L_A;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dur_q    <= dur_d;
      sym_q    <= sym_d;
      cnt_q    <= cnt_d;
      letter_q <= letter_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end

  assign bus.letter       = letter_q;
  assign bus.letter_valid = valid_q;
  assign bus.letter_err   = err_q;
  assign bus.busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_morse_rx_decoder.sv
// Scoreboard bench for morse_rx_decoder: expected {err,letter} events queued
// as letters are keyed, compared as pulses appear.
module tb_morse_rx_decoder;
  import morse_pkg::*;

  localparam int TP = 20;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0, n_fail = 0;
  logic [3:0] exp_q [$];
  letter_t last_letter = L_A;

  morse_rx_decoder_if bus ();
  morse_rx_decoder dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    bus.tick = 1'b0;
    forever begin
      repeat (TP - 1) @(negedge clk);
      bus.tick = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
    end
  end

  always @(negedge clk)
    if (bus.letter_valid || bus.letter_err) begin
      chk("excl", {31'd0, bus.letter_valid & bus.letter_err}, 32'd0);
      if (exp_q.size() == 0) chk("unexpected_pulse", {28'd0, bus.letter_err, bus.letter}, 32'hff);
      else chk("event", {28'd0, bus.letter_err, bus.letter}, {28'd0, exp_q.pop_front()});
    end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int g = 0;
      do begin @(posedge clk); g++; end while (!bus.tick && g < 4 * TP);
      if (!bus.tick) chk("tick_timeout", 0, 1);
    end
    @(negedge clk);
  endtask

  task automatic mark(input int n);
    bus.key_in = 1'b1; wait_ticks(n); bus.key_in = 1'b0;
  endtask

  task automatic space(input int n);
    bus.key_in = 1'b0; wait_ticks(n);
  endtask

  task automatic exp_ok(input letter_t c);
    exp_q.push_back({1'b0, c}); last_letter = c;
  endtask

  task automatic exp_err();
    exp_q.push_back({1'b1, last_letter});
  endtask

  task automatic drain(input string tag);
    int g = 0;
    while (exp_q.size() != 0 && g < 10 * TP) begin @(negedge clk); g++; end
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    bus.key_in = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_letter", {29'd0, bus.letter}, 32'd0);
    chk("rst_busy",   {31'd0, bus.busy}, 32'd0);
    chk("rst_pulses", {30'd0, bus.letter_valid, bus.letter_err}, 32'd0);
    reset = 1'b1;
    wait_ticks(1);

    // A
    mark(1); space(1); mark(3);
    exp_ok(L_A);
    space(3);
    chk("A_vld_lat", {31'd0, bus.letter_valid}, 32'd1);
    @(negedge clk);
    chk("A_busy_after", {31'd0, bus.busy}, 32'd0);
    drain("A_drain");

    // H then D
    for (int i = 0; i < 4; i++) begin mark(1); if (i < 3) space(1); end
    exp_ok(L_H); space(3);
    mark(3); space(1); mark(1); space(1); mark(1);
    exp_ok(L_D); space(3);
    drain("HD_drain");
    chk("D_letter", {29'd0, bus.letter}, {29'd0, L_D});

    // unknown "--"
    mark(3); space(1); mark(3);
    exp_err(); space(3);
    drain("dd_drain");
    chk("dd_hold", {29'd0, bus.letter}, {29'd0, L_D});

    // five dots
    for (int i = 0; i < 4; i++) begin mark(1); space(1); end
    mark(1);
    exp_err(); space(3);
    drain("five_drain");

    // long mark
    bus.key_in = 1'b1; wait_ticks(4);
    chk("hold_busy", {31'd0, bus.busy}, 32'd1);
    wait_ticks(5); bus.key_in = 1'b0;
    exp_err(); space(3);
    drain("hold_drain");

    // reset mid-letter
    mark(1); space(1); mark(3); space(1);
    chk("mid_busy", {31'd0, bus.busy}, 32'd1);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_letter", {29'd0, bus.letter}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    reset = 1'b1;
    last_letter = L_A;
    wait_ticks(4);
    mark(2);
    exp_ok(L_E); space(3);
    drain("E_drain");
    chk("E_letter", {29'd0, bus.letter}, {29'd0, L_E});

    // glitch inside the intra-letter gap of an A
    mark(1);
    repeat (3) @(negedge clk);
    bus.key_in = 1'b1;
    repeat (10) @(negedge clk);
    bus.key_in = 1'b0;
    wait_ticks(1);
    mark(3);
`ifdef MORSE_RX_GLITCH_EN
    exp_ok(L_A);
`else
    exp_err();
`endif
    space(3);
    drain("glitch_drain");
    space(2);
    chk("final_busy", {31'd0, bus.busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
